// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. A single PC generator requests ISSUE_W
// instructions per grant and buffers them in an IBUF_DEPTH-entry circular
// queue of {inst, pc, adel}, so a decode stall does not freeze the PC.
// Redirect priority: exception > ERET > branch/jump > if_cln flush.
//
// Optional feature macro: IF_FETCH_BYPASS_EN
//   When defined, a response arriving while the queue is empty is shown on
//   the ID lanes in the same cycle, and is written to the queue only if ID
//   does not accept it.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   imem_req     fetch request (imem_addr valid while high)
//   imem_addr    address of lane 0; lane k at imem_addr+4k
//   imem_gnt     request accepted this cycle
//   imem_rdata   ISSUE_W instruction words, valid 1 cycle after grant
//   exc_valid    exception taken, redirect to EXC_VEC
//   eret_valid   return, redirect to cp0_epc
//   cp0_epc      ERET target
//   br_valid     taken branch/jump, redirect to br_target
//   br_target    resolved branch target
//   if_cln       flush queue and drop in-flight response, PC unchanged
//   id_valid     per-lane valid, contiguous from lane 0
//   id_inst      per-lane instruction (0 when invalid)
//   id_pc        per-lane PC (0 when invalid)
//   id_adel      per-lane misaligned-fetch flag
//   id_accept    ID consumes every lane shown this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int          ISSUE_W    = 2,
  parameter int          IBUF_DEPTH = 8,
  parameter logic [31:0] RESET_VEC  = 32'hbfc0_0000,
  parameter logic [31:0] EXC_VEC    = 32'hbfc0_0380
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic [32*ISSUE_W-1:0]  imem_rdata,
  input  logic                   exc_valid,
  input  logic                   eret_valid,
  input  logic [31:0]            cp0_epc,
  input  logic                   br_valid,
  input  logic [31:0]            br_target,
  input  logic                   if_cln,
  output logic [ISSUE_W-1:0]     id_valid,
  output logic [32*ISSUE_W-1:0]  id_inst,
  output logic [32*ISSUE_W-1:0]  id_pc,
  output logic [ISSUE_W-1:0]     id_adel,
  input  logic                   id_accept
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_reqPc;
  logic          r_inflight;
  logic          r_halt;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_qInst [IBUF_DEPTH];
  logic [31:0]   r_qPc   [IBUF_DEPTH];
  logic          r_qAdel [IBUF_DEPTH];

  logic          w_redirect;
  logic          w_misaligned;
  int            w_free;
  logic          w_grant;
  logic          w_respValid;
  logic          w_misPush;
  logic          w_bypass;
  logic          w_pushGroup;
  logic [CW-1:0] w_shown;
  logic [CW-1:0] w_popCnt;
  logic [CW-1:0] w_pushCnt;

  // Request gating and push/pop bookkeeping. A grant can never coincide
  // with a redirect (the request is suppressed that cycle), so the only
  // response that can go stale is one arriving in the redirect cycle itself;
  // dropping it there is equivalent to marking it stale.
  always_comb begin
    w_redirect   = exc_valid | eret_valid | br_valid | if_cln;
    w_misaligned = (r_pc[1:0] != 2'b00);
    w_free       = IBUF_DEPTH - int'(r_count) - (r_inflight ? 2 : 0);
    imem_req     = reset && !w_redirect && !r_halt && !w_misaligned &&
                   (w_free >= ISSUE_W);
    imem_addr    = r_pc;
    w_grant      = imem_req & imem_gnt;
    w_respValid  = r_inflight & ~w_redirect;
    w_misPush    = w_misaligned & ~r_halt & ~w_redirect & ~w_respValid &
                   (r_count < CW'(IBUF_DEPTH));
    w_shown      = (r_count < CW'(ISSUE_W)) ? r_count : CW'(ISSUE_W);
`ifdef IF_FETCH_BYPASS_EN
    w_bypass     = w_respValid && (r_count == '0);
`else
    w_bypass     = 1'b0;
`endif
    w_popCnt     = (!w_bypass && id_accept) ? w_shown : '0;
    w_pushGroup  = w_respValid && !(w_bypass && id_accept);
    if (w_pushGroup)
      w_pushCnt = CW'(ISSUE_W);
    else if (w_misPush)
      w_pushCnt = CW'(1);
    else
      w_pushCnt = '0;
  end

  // ID lanes: oldest min(count, ISSUE_W) queue entries, or the live response
  // when bypassing an empty queue. Invalid lanes are forced to zero.
  always_comb begin
    id_valid = '0;
    id_inst  = '0;
    id_pc    = '0;
    id_adel  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (w_bypass) begin
        id_valid[k]        = 1'b1;
        id_inst[32*k +: 32] = imem_rdata[32*k +: 32];
        id_pc[32*k +: 32]   = r_reqPc + 32'(4*k);
      end else if (CW'(k) < w_shown) begin
        id_valid[k]        = 1'b1;
        id_inst[32*k +: 32] = r_qInst[r_rdPtr + PW'(k)];
        id_pc[32*k +: 32]   = r_qPc[r_rdPtr + PW'(k)];
        id_adel[k]         = r_qAdel[r_rdPtr + PW'(k)];
      end
    end
  end

  // Control state: PC, in-flight tracking, halt and queue pointers. Redirects
  // empty the queue and clear the address-error halt in the cycle asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_VEC;
      r_reqPc    <= RESET_VEC;
      r_inflight <= 1'b0;
      r_halt     <= 1'b0;
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_grant;
      if (w_grant)
        r_reqPc <= r_pc;
      if (exc_valid)
        r_pc <= EXC_VEC;
      else if (eret_valid)
        r_pc <= cp0_epc;
      else if (br_valid)
        r_pc <= br_target;
      else if (w_grant)
        r_pc <= r_pc + 32'(4*ISSUE_W);
      if (w_redirect)
        r_halt <= 1'b0;
      else if (w_misPush)
        r_halt <= 1'b1;
      if (w_redirect) begin
        r_count <= '0;
        r_rdPtr <= '0;
        r_wrPtr <= '0;
      end else begin
        r_count <= r_count + w_pushCnt - w_popCnt;
        r_rdPtr <= r_rdPtr + w_popCnt[PW-1:0];
        r_wrPtr <= r_wrPtr + w_pushCnt[PW-1:0];
      end
    end
  end

  // Queue storage. Needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (w_pushGroup) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        r_qInst[r_wrPtr + PW'(k)] <= imem_rdata[32*k +: 32];
        r_qPc[r_wrPtr + PW'(k)]   <= r_reqPc + 32'(4*k);
        r_qAdel[r_wrPtr + PW'(k)] <= 1'b0;
      end
    end else if (w_misPush) begin
      r_qInst[r_wrPtr] <= 32'h0;
      r_qPc[r_wrPtr]   <= r_pc;
      r_qAdel[r_wrPtr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit (ISSUE_W=2, IBUF_DEPTH=8).
// The memory model returns a fixed function of each word address, so every
// lane delivered to ID can be checked against the PC it claims. The stream
// reference is an expected next-fetch address and an expected next-ID PC,
// both reloaded on redirects.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int          W         = 2;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] RESET_VEC = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VEC   = 32'hbfc0_0380;
`ifdef IF_FETCH_BYPASS_EN
  localparam int          LAT       = 1;
`else
  localparam int          LAT       = 2;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt;
  logic [32*W-1:0] imem_rdata;
  logic            exc_valid;
  logic            eret_valid;
  logic [31:0]     cp0_epc;
  logic            br_valid;
  logic [31:0]     br_target;
  logic            if_cln;
  logic [W-1:0]    id_valid;
  logic [32*W-1:0] id_inst;
  logic [32*W-1:0] id_pc;
  logic [W-1:0]    id_adel;
  logic            id_accept;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_unit #(
    .ISSUE_W(W), .IBUF_DEPTH(DEPTH), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC)
  ) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rdata(imem_rdata), .exc_valid(exc_valid),
    .eret_valid(eret_valid), .cp0_epc(cp0_epc), .br_valid(br_valid),
    .br_target(br_target), .if_cln(if_cln), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel), .id_accept(id_accept)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Memory port model: data for a granted request appears the next cycle;
  // otherwise the bus carries random junk that must never reach ID.
  always @(posedge clk) begin
    logic [32*W-1:0] tmp;
    for (int k = 0; k < W; k++) begin
      if (imem_req && imem_gnt)
        tmp[32*k +: 32] = memWord(imem_addr + 32'(4*k));
      else
        tmp[32*k +: 32] = $urandom;
    end
    imem_rdata <= tmp;
  end

  task automatic clearInputs();
    imem_gnt = 0; exc_valid = 0; eret_valid = 0; cp0_epc = 0;
    br_valid = 0; br_target = 0; if_cln = 0; id_accept = 0;
  endtask

  // Leaves the bench in the low clock phase with reset just released; the
  // caller's next drive/#1/check is cycle 0.
  task automatic resetDut();
    @(negedge clk);
    reset = 0;
    clearInputs();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 0;
    clearInputs();
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    vectors++;
    if (imem_addr !== RESET_VEC) begin miscompares++; $display("[TB] FAIL rst_addr: got %h want %h", imem_addr, RESET_VEC); end
    vectors++;
    if (id_valid !== '0 || id_adel !== '0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b/%b want 0/0", id_valid, id_adel); end
    vectors++;
    if (id_inst !== '0 || id_pc !== '0) begin miscompares++; $display("[TB] FAIL rst_data: got %h/%h want 0", id_inst, id_pc); end
    repeat (2) @(negedge clk);
    reset = 1;
    imem_gnt = 1;
    id_accept = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c < 3) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_VEC + 32'(8*c)) begin
          miscompares++;
          $display("[TB] FAIL rel_addr%0d: got %b/%h want 1/%h", c, imem_req, imem_addr, RESET_VEC + 32'(8*c));
        end
      end
      if (c < LAT) begin
        vectors++;
        if (id_valid !== '0) begin miscompares++; $display("[TB] FAIL rel_early%0d: got %b want 00", c, id_valid); end
      end else if (c == LAT) begin
        vectors++;
        if (id_valid !== 2'b11 || id_pc !== {RESET_VEC + 32'd4, RESET_VEC}) begin
          miscompares++;
          $display("[TB] FAIL rel_first: got %b/%h want 11/%h", id_valid, id_pc, {RESET_VEC + 32'd4, RESET_VEC});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_queue();
    logic [31:0] expId;
    int lanes;
    resetDut();
    imem_gnt = 1;
    id_accept = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 5) begin
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL full_req%0d: got %b want 0", c, imem_req); end
      end
      @(negedge clk);
    end
    vectors++;
    if (dut.r_count !== 4'd8) begin miscompares++; $display("[TB] FAIL full_count: got %0d want 8", dut.r_count); end
    expId = RESET_VEC;
    id_accept = 1;
    for (int c = 0; c < 16; c++) begin
      #1;
      lanes = $countones(id_valid);
      vectors++;
      if (id_valid !== 2'b11) begin
        miscompares++;
        $display("[TB] FAIL drain_gap%0d: got %b want 11", c, id_valid);
      end
      for (int k = 0; k < lanes; k++) begin
        vectors++;
        if (id_pc[32*k +: 32] !== expId + 32'(4*k) || id_inst[32*k +: 32] !== memWord(expId + 32'(4*k))) begin
          miscompares++;
          $display("[TB] FAIL drain_pc%0d: got %h/%h want %h", c, id_pc[32*k +: 32], id_inst[32*k +: 32], expId + 32'(4*k));
        end
      end
      expId = expId + 32'(4*lanes);
      @(negedge clk);
    end
  endtask

  task automatic test_branch_inflight();
    logic [31:0] expId;
    logic [31:0] tgt;
    bit seen;
    int lanes;
    tgt = 32'hbfc0_1000;
    resetDut();
    imem_gnt = 1;
    id_accept = 1;
    repeat (3) begin #1; @(negedge clk); end
    br_valid = 1;
    br_target = tgt;
    id_accept = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL br_req: got %b want 0", imem_req); end
    @(negedge clk);
    br_valid = 0;
    id_accept = 1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== tgt) begin miscompares++; $display("[TB] FAIL br_addr: got %b/%h want 1/%h", imem_req, imem_addr, tgt); end
    vectors++;
    if (id_valid !== '0) begin miscompares++; $display("[TB] FAIL br_flush: got %b want 00", id_valid); end
    expId = tgt;
    seen = 0;
    @(negedge clk);
    for (int c = 1; c < 8; c++) begin
      #1;
      lanes = $countones(id_valid);
      if (c == LAT) begin
        vectors++;
        if (id_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL br_lat: got %b want 11", id_valid); end
      end
      for (int k = 0; k < lanes; k++) begin
        seen = 1;
        vectors++;
        if (id_pc[32*k +: 32] !== expId + 32'(4*k)) begin
          miscompares++;
          $display("[TB] FAIL br_oldpc%0d: got %h want %h", c, id_pc[32*k +: 32], expId + 32'(4*k));
        end
      end
      expId = expId + 32'(4*lanes);
      @(negedge clk);
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL br_timeout: got no lanes want lanes"); end
  endtask

  task automatic test_priority();
    resetDut();
    exc_valid = 1; eret_valid = 1; cp0_epc = 32'h8000_0100;
    br_valid = 1; br_target = 32'hbfc0_1000;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL pri_req: got %b want 0", imem_req); end
    @(negedge clk);
    clearInputs();
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== EXC_VEC) begin miscompares++; $display("[TB] FAIL pri_exc: got %b/%h want 1/%h", imem_req, imem_addr, EXC_VEC); end
    @(negedge clk);
    eret_valid = 1; cp0_epc = 32'h8000_0100; br_valid = 1; br_target = 32'hbfc0_1000;
    @(negedge clk);
    clearInputs();
    #1;
    vectors++;
    if (imem_addr !== 32'h8000_0100) begin miscompares++; $display("[TB] FAIL pri_eret: got %h want 80000100", imem_addr); end
    @(negedge clk);
    br_valid = 1; br_target = 32'hbfc0_2000; if_cln = 1;
    @(negedge clk);
    clearInputs();
    #1;
    vectors++;
    if (imem_addr !== 32'hbfc0_2000) begin miscompares++; $display("[TB] FAIL pri_br: got %h want bfc02000", imem_addr); end
    @(negedge clk);
    if_cln = 1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL cln_req: got %b want 0", imem_req); end
    @(negedge clk);
    clearInputs();
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hbfc0_2000) begin miscompares++; $display("[TB] FAIL cln_keep: got %b/%h want 1/bfc02000", imem_req, imem_addr); end
  endtask

  task automatic test_adel();
    resetDut();
    imem_gnt = 1;
    id_accept = 1;
    br_valid = 1;
    br_target = 32'hbfc0_0002;
    #1;
    @(negedge clk);
    br_valid = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL adel_req: got %b want 0", imem_req); end
    @(negedge clk);
    #1;
    vectors++;
    if (id_valid !== 2'b01 || id_adel !== 2'b01) begin miscompares++; $display("[TB] FAIL adel_flag: got %b/%b want 01/01", id_valid, id_adel); end
    vectors++;
    if (id_inst !== '0 || id_pc !== {32'h0, 32'hbfc0_0002}) begin miscompares++; $display("[TB] FAIL adel_data: got %h/%h want 0/bfc00002", id_inst, id_pc); end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0 || id_valid !== '0) begin miscompares++; $display("[TB] FAIL adel_halt%0d: got %b/%b want 0/00", c, imem_req, id_valid); end
      @(negedge clk);
    end
    eret_valid = 1;
    cp0_epc = 32'hbfc0_0100;
    #1;
    @(negedge clk);
    eret_valid = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hbfc0_0100) begin miscompares++; $display("[TB] FAIL adel_resume: got %b/%h want 1/bfc00100", imem_req, imem_addr); end
  endtask

  task automatic test_midreset();
    resetDut();
    imem_gnt = 1;
    id_accept = 0;
    repeat (4) begin #1; @(negedge clk); end
    #1;
    reset = 0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_VEC || id_valid !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst: got %b/%h/%b want 0/%h/00", imem_req, imem_addr, id_valid, RESET_VEC);
    end
    @(negedge clk);
    reset = 1;
    id_accept = 1;
    for (int c = 0; c <= LAT; c++) begin
      #1;
      vectors++;
      if (c < LAT && id_valid !== '0) begin
        miscompares++;
        $display("[TB] FAIL midrst_stale%0d: got %b want 00", c, id_valid);
      end else if (c == LAT && (id_valid !== 2'b11 || id_pc[31:0] !== RESET_VEC)) begin
        miscompares++;
        $display("[TB] FAIL midrst_first: got %b/%h want 11/%h", id_valid, id_pc[31:0], RESET_VEC);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] expFetch, expId, tgt;
    int lanes;
    bit redir;
    resetDut();
    expFetch = RESET_VEC;
    expId = RESET_VEC;
    for (int c = 0; c < 400; c++) begin
      redir = ($urandom_range(0, 39) == 0);
      tgt = 32'hbfc1_0000 | ($urandom & 32'h0000_fffc);
      imem_gnt = ($urandom_range(0, 9) < 7);
      br_valid = redir;
      br_target = tgt;
      id_accept = redir ? 1'b0 : ($urandom_range(0, 9) < 6);
      #1;
      if (redir) begin
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd_redir%0d: got %b want 0", c, imem_req); end
        expFetch = tgt;
        expId = tgt;
      end else begin
        if (imem_req && imem_gnt) begin
          vectors++;
          if (imem_addr !== expFetch) begin miscompares++; $display("[TB] FAIL rnd_addr%0d: got %h want %h", c, imem_addr, expFetch); end
          expFetch = expFetch + 32'(4*W);
        end
        lanes = $countones(id_valid);
        vectors++;
        if (id_valid !== W'((1 << lanes) - 1) || (lanes < W && (id_inst[63:32] !== '0 || id_pc[63:32] !== '0))) begin
          miscompares++;
          $display("[TB] FAIL rnd_lanes%0d: got %b/%h want contiguous, zero idle", c, id_valid, id_pc);
        end
        for (int k = 0; k < lanes; k++) begin
          vectors++;
          if (id_pc[32*k +: 32] !== expId + 32'(4*k) || id_inst[32*k +: 32] !== memWord(expId + 32'(4*k)) || id_adel[k] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rnd_pc%0d: got %h/%h want %h/%h", c, id_pc[32*k +: 32], id_inst[32*k +: 32], expId + 32'(4*k), memWord(expId + 32'(4*k)));
          end
        end
        if (id_accept)
          expId = expId + 32'(4*lanes);
      end
      @(negedge clk);
    end
    clearInputs();
    id_accept = 1;
    for (int c = 0; c < 12 && expId != expFetch; c++) begin
      #1;
      lanes = $countones(id_valid);
      for (int k = 0; k < lanes; k++) begin
        vectors++;
        if (id_pc[32*k +: 32] !== expId + 32'(4*k)) begin
          miscompares++;
          $display("[TB] FAIL drn_pc%0d: got %h want %h", c, id_pc[32*k +: 32], expId + 32'(4*k));
        end
      end
      expId = expId + 32'(4*lanes);
      @(negedge clk);
    end
    vectors++;
    if (expId !== expFetch) begin miscompares++; $display("[TB] FAIL rnd_lost: got %h want %h", expId, expFetch); end
  endtask

`ifdef IF_FETCH_BYPASS_EN
  task automatic test_bypass();
    resetDut();
    imem_gnt = 1;
    id_accept = 1;
    #1;
    @(negedge clk);
    #1;
    vectors++;
    if (id_valid !== 2'b11 || id_pc !== {RESET_VEC + 32'd4, RESET_VEC}) begin
      miscompares++;
      $display("[TB] FAIL byp_lat: got %b/%h want 11/%h", id_valid, id_pc, {RESET_VEC + 32'd4, RESET_VEC});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (dut.r_count !== 4'd0) begin miscompares++; $display("[TB] FAIL byp_count%0d: got %0d want 0", c, dut.r_count); end
    end
  endtask
`endif

  initial begin
    reset = 0;
    clearInputs();
    test_reset();
    test_full_queue();
    test_branch_inflight();
    test_priority();
    test_adel();
    test_midreset();
    test_random_stream();
`ifdef IF_FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
